// File: rtl/pc_seq_pkg.sv
// Shared definitions for the IF-stage program-counter sequencer and the
// trap-handler logic that reuses its default vectors.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_FAULT = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VEC  = 32'h0000_0080;

    // Mask covering the low `bits` address bits; zero bits yields an empty mask.
    function automatic logic [63:0] low_mask(input int unsigned bits);
        if (bits == 0) begin
            return '0;
        end
        return (64'd1 << bits) - 64'd1;
    endfunction

endpackage

// File: rtl/pc_step_adder.sv
// Combinational PC incrementer: sum_o = addr_i + STEP, wrapping modulo 2^ADDR_W.
module pc_step_adder #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned STEP   = 4
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [ADDR_W-1:0] sum_o
);

    localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

    assign sum_o = addr_i + STEP_W;

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter for the IF stage with fetch handshake, stall hold,
// aligned branch/jump redirect, trap vectoring, fault halt and redirect counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STEP       = 4,
    parameter logic [31:0] RESET_VEC  = DEFAULT_RESET_VEC,
    parameter logic [31:0] TRAP_VEC   = DEFAULT_TRAP_VEC,
    parameter int unsigned ALIGN_BITS = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              fetch_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              trap,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_step,
    output logic              fetch_valid,
    output logic              fault,
    output logic [CNT_W-1:0]  redirect_cnt
);

    localparam logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] TRAP_PC    = ADDR_W'(TRAP_VEC);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(low_mask(ALIGN_BITS));

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              misaligned;
    logic              advance;

    pc_step_adder #(
        .ADDR_W (ADDR_W),
        .STEP   (STEP)
    ) u_step (
        .addr_i (pc_q),
        .sum_o  (pc_plus_step)
    );

    assign misaligned = |(redirect_target & ALIGN_MASK);
    assign advance    = fetch_valid & fetch_ready & ~stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
                if (trap) begin
                    pc_d = TRAP_PC;
                end
            end
            S_RUN: begin
                // Priority: trap > redirect > stall > advance.
                if (trap) begin
                    pc_d = TRAP_PC;
                end else if (redirect_valid) begin
                    if (misaligned) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d = redirect_target;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end else if (advance) begin
                    pc_d = pc_plus_step;
                end
            end
            S_FAULT: begin
                if (trap) begin
                    pc_d    = TRAP_PC;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc           = pc_q;
    assign fetch_valid  = (state_q == S_RUN);
    assign fault        = (state_q == S_FAULT);
    assign redirect_cnt = cnt_q;

endmodule
